// File: rtl/fast_slow_hold.sv
// Fast-clock half of a fast->slow transfer: stages the newest input word and loads a hold
// register on each synchronised slow_clk edge. Define FAST_SLOW_HOLD_PERIOD_MEAS_EN for period measurement.
module fast_slow_hold #(
    parameter int WIDTH       = 12,
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PER_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      slow_clk,
    input  logic                      mode_fall,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_stb,
    output logic                      stale,
    output logic [CNT_W-1:0]          overrun_cnt,
    output logic [PER_W-1:0]          period,
    output logic                      period_vld
);

    localparam int DW = CHANNELS * WIDTH;

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   s;
    logic                   s_d_q;
    logic                   primed;
    logic                   mode_q;
    logic                   mode_chg;
    logic                   ev;
    logic                   cap;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [DW-1:0]    stage_q;
    logic [DW-1:0]    stage_d;
    logic             stage_full_q;
    logic             stage_full_d;
    logic [DW-1:0]    out_q;
    logic [DW-1:0]    out_d;
    logic             stb_q;
    logic             stb_d;
    logic             stale_q;
    logic             stale_d;
    logic [CNT_W-1:0] ovr_q;
    logic [CNT_W-1:0] ovr_d;

    // prime_q fills with ones alongside the synchroniser, so the reset-cleared
    // chain is never mistaken for a genuine inactive slow_clk level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prime_q <= '0;
            s_d_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            s_d_q   <= s;
            mode_q  <= mode_fall;
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign primed   = prime_q[SYNC_STAGES-1];
    assign mode_chg = mode_fall ^ mode_q;
    assign ev       = mode_fall ? (s_d_q & ~s) : (s & ~s_d_q);
    assign cap      = (state_q == ST_RUN) && ev;

    always_comb begin
        state_d = state_q;
        if (mode_chg) begin
            state_d = ST_WAIT;
        end else if ((state_q == ST_WAIT) && primed && (s == mode_fall)) begin
            state_d = ST_RUN;
        end
    end

    // One overrun per cycle at most: a valid word always displaces a pending staged word,
    // whether it goes to the stage or straight to the hold register.
    always_comb begin
        stage_d      = stage_q;
        stage_full_d = stage_full_q;
        out_d        = out_q;
        stale_d      = stale_q;
        stb_d        = 1'b0;
        ovr_d        = ovr_q;

        if (in_valid && stage_full_q && (ovr_q != '1)) begin
            ovr_d = ovr_q + 1'b1;
        end

        if (cap) begin
            stb_d        = 1'b1;
            stage_full_d = 1'b0;
            if (in_valid) begin
                out_d   = in_data;
                stale_d = 1'b0;
            end else if (stage_full_q) begin
                out_d   = stage_q;
                stale_d = 1'b0;
            end else begin
                stale_d = 1'b1;
            end
        end else if (in_valid) begin
            stage_d      = in_data;
            stage_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT;
            stage_q      <= '0;
            stage_full_q <= 1'b0;
            out_q        <= '0;
            stb_q        <= 1'b0;
            stale_q      <= 1'b0;
            ovr_q        <= '0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            stage_full_q <= stage_full_d;
            out_q        <= out_d;
            stb_q        <= stb_d;
            stale_q      <= stale_d;
            ovr_q        <= ovr_d;
        end
    end

    assign out_data    = out_q;
    assign out_stb     = stb_q;
    assign stale       = stale_q;
    assign overrun_cnt = ovr_q;

`ifdef FAST_SLOW_HOLD_PERIOD_MEAS_EN
    logic [PER_W-1:0] cnt_q;
    logic [PER_W-1:0] cnt_inc;
    logic [PER_W-1:0] per_q;
    logic             seen_q;
    logic             pvld_q;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // The first capture after arming only closes a partial interval, so it is not flagged valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            per_q  <= '0;
            seen_q <= 1'b0;
            pvld_q <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            cnt_q  <= '0;
            seen_q <= 1'b0;
            pvld_q <= 1'b0;
        end else if (cap) begin
            per_q  <= cnt_inc;
            cnt_q  <= '0;
            seen_q <= 1'b1;
            if (seen_q) begin
                pvld_q <= 1'b1;
            end
        end else begin
            cnt_q <= cnt_inc;
        end
    end

    assign period     = per_q;
    assign period_vld = pvld_q;
`else
    assign period     = '0;
    assign period_vld = 1'b0;
`endif

endmodule

// File: tb/tb_fast_slow_hold.sv
// Directed bench for fast_slow_hold: a cycle-by-cycle vector table plus hand-written
// sequences for reset arming, overrun saturation, mode switching and asynchronous reset.
module tb_fast_slow_hold;

    localparam int WIDTH    = 12;
    localparam int CHANNELS = 2;
    localparam int DW       = WIDTH * CHANNELS;
    localparam int CNT_W    = 8;
    localparam int PER_W    = 16;
    localparam int NVEC     = 40;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             slow_clk;
    logic             mode_fall;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic [DW-1:0]    out_data;
    logic             out_stb;
    logic             stale;
    logic [CNT_W-1:0] overrun_cnt;
    logic [PER_W-1:0] period;
    logic             period_vld;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic             slow;
        logic             iv;
        logic [DW-1:0]    data;
        logic             stb;
        logic [DW-1:0]    out;
        logic             stl;
        logic [CNT_W-1:0] ovr;
        logic [PER_W-1:0] per;
        logic             pvld;
    } vec_t;

    vec_t vecs [NVEC];

    fast_slow_hold dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slow_clk    (slow_clk),
        .mode_fall   (mode_fall),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_data    (out_data),
        .out_stb     (out_stb),
        .stale       (stale),
        .overrun_cnt (overrun_cnt),
        .period      (period),
        .period_vld  (period_vld)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the posedge.
    task automatic applyStimulus(input logic s, input logic iv, input logic [DW-1:0] d);
        slow_clk = s;
        in_valid = iv;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eStb, input logic [DW-1:0] eData,
                               input logic eStale, input logic [CNT_W-1:0] eOvr);
        checkCount++;
        if (out_stb === eStb && out_data === eData && stale === eStale && overrun_cnt === eOvr) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got stb=%0b data=%h stale=%0b ovr=%0d, want stb=%0b data=%h stale=%0b ovr=%0d",
                     name, out_stb, out_data, stale, overrun_cnt, eStb, eData, eStale, eOvr);
        end
    endtask

    task automatic checkPeriod(input string name, input logic [PER_W-1:0] ePer, input logic eVld);
        checkCount++;
        if (period === ePer && period_vld === eVld) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s_period: got period=%0d vld=%0b, want period=%0d vld=%0b",
                     name, period, period_vld, ePer, eVld);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checkCount++;
        if (got == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic setVec(input int i, input logic s, input logic iv, input logic [DW-1:0] d,
                          input logic stb, input logic [DW-1:0] o, input logic stl,
                          input logic [CNT_W-1:0] ovr, input logic [PER_W-1:0] per, input logic pvld);
        vecs[i] = '{s, iv, d, stb, o, stl, ovr, per, pvld};
    endtask

    initial begin
        int stbSeen;

        // idx  slow iv data         stb out          stale ovr per pvld
        setVec( 0, 0, 0, 24'h0,      0, 24'h0,      0, 0, 0, 0);
        setVec( 1, 0, 1, 24'h00000A, 0, 24'h0,      0, 0, 0, 0);
        setVec( 2, 0, 1, 24'h00000B, 0, 24'h0,      0, 1, 0, 0);
        setVec( 3, 1, 1, 24'h00000C, 0, 24'h0,      0, 2, 0, 0);
        setVec( 4, 1, 0, 24'h0,      0, 24'h0,      0, 2, 0, 0);
        setVec( 5, 1, 0, 24'h0,      1, 24'h00000C, 0, 2, 3, 0);
        setVec( 6, 1, 0, 24'h0,      0, 24'h00000C, 0, 2, 3, 0);
        setVec( 7, 0, 0, 24'h0,      0, 24'h00000C, 0, 2, 3, 0);
        setVec( 8, 0, 0, 24'h0,      0, 24'h00000C, 0, 2, 3, 0);
        setVec( 9, 0, 1, 24'h123456, 0, 24'h00000C, 0, 2, 3, 0);
        setVec(10, 0, 0, 24'h0,      0, 24'h00000C, 0, 2, 3, 0);
        setVec(11, 1, 0, 24'h0,      0, 24'h00000C, 0, 2, 3, 0);
        setVec(12, 1, 0, 24'h0,      0, 24'h00000C, 0, 2, 3, 0);
        setVec(13, 1, 0, 24'h0,      1, 24'h123456, 0, 2, 8, 1);
        setVec(14, 1, 0, 24'h0,      0, 24'h123456, 0, 2, 8, 1);
        setVec(15, 0, 0, 24'h0,      0, 24'h123456, 0, 2, 8, 1);
        setVec(16, 0, 0, 24'h0,      0, 24'h123456, 0, 2, 8, 1);
        setVec(17, 0, 0, 24'h0,      0, 24'h123456, 0, 2, 8, 1);
        setVec(18, 0, 0, 24'h0,      0, 24'h123456, 0, 2, 8, 1);
        setVec(19, 1, 0, 24'h0,      0, 24'h123456, 0, 2, 8, 1);
        setVec(20, 1, 0, 24'h0,      0, 24'h123456, 0, 2, 8, 1);
        setVec(21, 1, 1, 24'h000777, 1, 24'h000777, 0, 2, 8, 1);
        setVec(22, 1, 0, 24'h0,      0, 24'h000777, 0, 2, 8, 1);
        setVec(23, 0, 0, 24'h0,      0, 24'h000777, 0, 2, 8, 1);
        setVec(24, 0, 0, 24'h0,      0, 24'h000777, 0, 2, 8, 1);
        setVec(25, 0, 0, 24'h0,      0, 24'h000777, 0, 2, 8, 1);
        setVec(26, 0, 0, 24'h0,      0, 24'h000777, 0, 2, 8, 1);
        setVec(27, 1, 0, 24'h0,      0, 24'h000777, 0, 2, 8, 1);
        setVec(28, 1, 0, 24'h0,      0, 24'h000777, 0, 2, 8, 1);
        setVec(29, 1, 0, 24'h0,      1, 24'h000777, 1, 2, 8, 1);
        setVec(30, 1, 0, 24'h0,      0, 24'h000777, 1, 2, 8, 1);
        setVec(31, 0, 1, 24'h0000AA, 0, 24'h000777, 1, 2, 8, 1);
        setVec(32, 0, 0, 24'h0,      0, 24'h000777, 1, 2, 8, 1);
        setVec(33, 0, 0, 24'h0,      0, 24'h000777, 1, 2, 8, 1);
        setVec(34, 0, 0, 24'h0,      0, 24'h000777, 1, 2, 8, 1);
        setVec(35, 1, 0, 24'h0,      0, 24'h000777, 1, 2, 8, 1);
        setVec(36, 1, 0, 24'h0,      0, 24'h000777, 1, 2, 8, 1);
        setVec(37, 1, 1, 24'h0000BB, 1, 24'h0000BB, 0, 3, 8, 1);
        setVec(38, 1, 0, 24'h0,      0, 24'h0000BB, 0, 3, 8, 1);
        setVec(39, 0, 0, 24'h0,      0, 24'h0000BB, 0, 3, 8, 1);

        rst_n     = 1'b1;
        slow_clk  = 1'b0;
        mode_fall = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset", 1'b0, '0, 1'b0, '0);
        checkPeriod("reset", '0, 1'b0);
        #9 rst_n = 1'b1;

        $display("[TB] vector table, rise mode");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].slow, vecs[i].iv, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].stb, vecs[i].out, vecs[i].stl, vecs[i].ovr);
`ifdef FAST_SLOW_HOLD_PERIOD_MEAS_EN
            checkPeriod($sformatf("vec%0d", i), vecs[i].per, vecs[i].pvld);
`else
            checkPeriod($sformatf("vec%0d", i), '0, 1'b0);
`endif
        end

        $display("[TB] overrun saturation, 200 slow periods of three words each");
        stbSeen = 0;
        for (int rep = 0; rep < 200; rep++) begin
            for (int c = 0; c < 8; c++) begin
                applyStimulus(c >= 4, c < 3, DW'(24'h00000A + c));
                stbSeen += int'(out_stb);
            end
            if (rep == 0) begin
                checkOutput("sat_rep0", 1'b0, 24'h00000C, 1'b0, 8'd5);
            end
        end
        checkValue("sat_strobes", stbSeen, 200);
        checkOutput("sat_final", 1'b0, 24'h00000C, 1'b0, 8'd255);

        $display("[TB] switch to fall mode mid-run");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput($sformatf("mode_low%0d", c), 1'b0, 24'h00000C, 1'b0, 8'd255);
        end
        mode_fall = 1'b1;
        for (int c = 3; c < 6; c++) begin
            applyStimulus(1'b0, c == 4, 24'h0005A5);
            checkOutput($sformatf("mode_low%0d", c), 1'b0, 24'h00000C, 1'b0, 8'd255);
        end
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput($sformatf("mode_high%0d", c), 1'b0, 24'h00000C, 1'b0, 8'd255);
        end
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput($sformatf("mode_fall%0d", c), 1'b0, 24'h00000C, 1'b0, 8'd255);
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("mode_fall_cap", 1'b1, 24'h0005A5, 1'b0, 8'd255);
        applyStimulus(1'b0, 1'b0, '0);

        $display("[TB] asynchronous reset mid-period");
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, '0, 1'b0, '0);
        checkPeriod("async_reset", '0, 1'b0);

        $display("[TB] reset released with slow_clk already high");
        mode_fall = 1'b0;
        slow_clk  = 1'b1;
        in_valid  = 1'b1;
        in_data   = 24'h000111;
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 24'h000111);
        checkOutput("arm_x0", 1'b0, '0, 1'b0, '0);
        for (int c = 1; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput($sformatf("arm_x%0d", c), 1'b0, '0, 1'b0, '0);
        end
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput($sformatf("arm_y%0d", c), 1'b0, '0, 1'b0, '0);
        end
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput($sformatf("arm_z%0d", c), 1'b0, '0, 1'b0, '0);
        end
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("arm_cap", 1'b1, 24'h000111, 1'b0, '0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
